// File: rtl/ctrl_sequencer.sv
// Multicycle LEGv8 control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with memory handshakes.
// Optional feature macro CTRL_BRANCH_EN enables CBZ and B; without it they decode as illegal.
module ctrl_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_en,
    output logic        pc_src,
    output logic        alu_src,
    output logic [3:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [15:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_RTYPE, C_ITYPE, C_LDUR, C_STUR, C_CBZ, C_B
    } cls_t;

    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0111;

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d, dec_cls;
    logic [3:0]  alu_op_q, alu_op_d, dec_op;
    logic [15:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        is_branch, br_taken, retire_ev;

    always_comb begin
        dec_cls = C_NONE;
        dec_op  = ALU_AND;
        casez (opcode)
            11'b10001011000: begin dec_cls = C_RTYPE; dec_op = ALU_ADD; end
            11'b11001011000: begin dec_cls = C_RTYPE; dec_op = ALU_SUB; end
            11'b10001010000: begin dec_cls = C_RTYPE; dec_op = ALU_AND; end
            11'b10101010000: begin dec_cls = C_RTYPE; dec_op = ALU_OR;  end
            11'b1001000100?: begin dec_cls = C_ITYPE; dec_op = ALU_ADD; end
            11'b1101000100?: begin dec_cls = C_ITYPE; dec_op = ALU_SUB; end
            11'b11111000010: begin dec_cls = C_LDUR;  dec_op = ALU_ADD; end
            11'b11111000000: begin dec_cls = C_STUR;  dec_op = ALU_ADD; end
`ifdef CTRL_BRANCH_EN
            11'b10110100???: begin dec_cls = C_CBZ;   dec_op = ALU_PASS; end
            11'b000101?????: begin dec_cls = C_B;     dec_op = ALU_PASS; end
`endif
            default: ;
        endcase
    end

`ifdef CTRL_BRANCH_EN
    assign is_branch = (cls_q == C_CBZ) || (cls_q == C_B);
    assign br_taken  = (state_q == S_EXECUTE) && ((cls_q == C_B) || ((cls_q == C_CBZ) && zero));
`else
    logic unused_zero;
    assign unused_zero = zero;
    assign is_branch   = 1'b0;
    assign br_taken    = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cls_q     <= C_NONE;
            alu_op_q  <= 4'b0000;
            retired_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            alu_op_q  <= alu_op_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = (dec_cls == C_NONE) ? S_TRAP : S_EXECUTE;
            S_EXECUTE: begin
                case (cls_q)
                    C_RTYPE, C_ITYPE: state_d = S_WB;
                    C_LDUR, C_STUR:   state_d = S_MEM;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM:    if (dmem_ready) state_d = (cls_q == C_LDUR) ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Class and ALU op are only refreshed in DECODE so later states see a stable value.
    always_comb begin
        cls_d    = cls_q;
        alu_op_d = alu_op_q;
        if (state_q == S_DECODE) begin
            cls_d    = dec_cls;
            alu_op_d = dec_op;
        end
        retire_ev = (state_q == S_WB)
                  || ((state_q == S_MEM) && dmem_ready && (cls_q == C_STUR))
                  || ((state_q == S_EXECUTE) && is_branch);
        retired_d = retired_q + {15'd0, retire_ev};
        illegal_d = illegal_q || ((state_q == S_DECODE) && (dec_cls == C_NONE));
    end

    always_comb begin
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        alu_src    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
                pc_en    = imem_ready;
            end
            S_EXECUTE: begin
                alu_src = (cls_q == C_ITYPE) || (cls_q == C_LDUR) || (cls_q == C_STUR);
                pc_en   = br_taken;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STUR);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LDUR);
            end
            default: ;
        endcase
    end

    assign pc_src  = br_taken;
    assign alu_op  = alu_op_q;
    assign illegal = illegal_q;
    assign retired = retired_q;
endmodule
